instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter INSTRUCTION_WIDTH, default 32; width of one instruction word.
REQ-002 Parameter INSTRUCTION_COUNT, default 8; program length in words. Addresses are 0..INSTRUCTION_COUNT-1.
REQ-003 Parameter BRAM_LATENCY, default 2; fixed read latency of the program BRAM, in cycles.
REQ-004 Parameter FIFO_DEPTH, default 4; instruction buffer entries, a power of two, at least 2.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk_in  input  1  system clock; all state updates on the rising edge.
REQ-007 rst_in  input  1  asynchronous active-high reset.
REQ-008 start_in  input  1  single-cycle pulse; begins fetching at address 0.
REQ-009 redirect_in  input  1  branch/jump from the controller; flushes buffered and in-flight fetches.
REQ-010 redirect_pc_in  input  $clog2(INSTRUCTION_COUNT+1)  new fetch address.
REQ-011 bram_addr_out  output  $clog2(INSTRUCTION_COUNT)  program BRAM read address.
REQ-012 bram_en_out  output  1  read issue strobe.
REQ-013 bram_data_in  input  INSTRUCTION_WIDTH  BRAM read data, valid BRAM_LATENCY cycles after an issue.
REQ-014 instr_out  output  INSTRUCTION_WIDTH  head instruction, delivered to the controller.
REQ-015 pc_out  output  $clog2(INSTRUCTION_COUNT+1)  address of instr_out.
REQ-016 instr_valid_out  output  1  head entry valid.
REQ-017 instr_ready_in  input  1  controller accepts; a transfer occurs when valid and ready are both high.
REQ-018 done_out  output  1  level; program exhausted and all buffers drained.

Function
REQ-019 FSM states: IDLE, FETCH, END.
- IDLE -> FETCH on start_in, with fetch pc set to 0.
- FETCH -> END when fetch pc reaches INSTRUCTION_COUNT.
- END -> IDLE once the FIFO is empty and no reads are in flight; done_out is asserted in that cycle and held while in IDLE.
REQ-020 In FETCH, bram_en_out is high iff (FIFO occupancy + in-flight reads) < FIFO_DEPTH and no redirect is pending in that cycle.
- When high, bram_addr_out equals fetch pc and fetch pc increments by 1.
REQ-021 An in-flight shift register, BRAM_LATENCY deep, carries a valid bit and pc per issue. Its output writes {bram_data_in, pc} into the FIFO in the cycle the data arrives.
REQ-022 The FIFO never overflows; the credit rule in REQ-020 guarantees this, and an overflow is an assertion failure.
REQ-023 instr_out, pc_out and instr_valid_out are driven from the FIFO head with zero added latency. Load-to-valid latency from issue is BRAM_LATENCY+1 cycles.
REQ-024 redirect_in, in any state:
- clears the FIFO and all in-flight valid bits in the same edge;
- sets fetch pc to redirect_pc_in;
- enters FETCH, or END if redirect_pc_in >= INSTRUCTION_COUNT.
REQ-025 Redirect and handshake in the same cycle: the head transfer counts as accepted; all other entries are discarded.
REQ-026 start_in while not IDLE is ignored. start_in and redirect_in together: redirect wins.
REQ-027 Full FIFO with instr_ready_in held low: no issues occur and outputs are held stable.
REQ-028 The pc field is one bit wider than the address, so pc==INSTRUCTION_COUNT is representable. There is no wrap-around; fetch never issues address INSTRUCTION_COUNT.
REQ-029 done_out clears on the edge that leaves IDLE.

Reset
REQ-030 rst_in asserted asynchronously forces the following, mid-operation included:
- state=IDLE;
- fetch pc=0;
- FIFO pointers and count=0;
- in-flight valid bits=0.
REQ-031 Output values during reset:
- bram_en_out=0, bram_addr_out=0;
- instr_valid_out=0, instr_out=0, pc_out=0;
- done_out=0.
REQ-032 After reset, no issue occurs until start_in. BRAM data still arriving from before reset is discarded.

Structure
REQ-033 Shared package gpu_pkg holds:
- INSTRUCTION_WIDTH;
- the fetch FSM state typedef;
- the fetch entry struct {instr, pc}.
The controller imports the same package.
REQ-034 One sub-module, instr_fifo, implements a synchronous FIFO with flush, count and full/empty.
REQ-035 Implementation size is 150-300 lines of RTL, excluding the package.

Verification
REQ-036 Use a behavioural BRAM model with 2-cycle latency, loaded with word=0xA000_0000+addr. Reset, start_in, ready always 1 -> instr_out sequence 0xA0000000..0xA0000007 with pc 0..7, then done_out=1.
REQ-037 Back-pressure: ready=0 for 20 cycles after start -> exactly 4 entries buffered, bram_en_out=0 throughout the stall, no loss or duplication after release.
REQ-038 Redirect to 5 while pc 2 is at head with ready=1 -> pc 2 is accepted, next delivered pc=5, then 6, 7, then done_out.
REQ-039 Redirect to 8 (== INSTRUCTION_COUNT) -> no issues, FIFO empty, done_out=1 within BRAM_LATENCY+1 cycles.
REQ-040 rst_in pulse mid-FETCH with reads in flight -> all outputs 0 immediately, no instruction delivered after reset until a new start_in, and the first delivered pc after that start is 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the instruction fetch path and the controller that consumes it.
package gpu_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int INSTRUCTION_COUNT = 8;
    localparam int PC_WIDTH          = $clog2(INSTRUCTION_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_END   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]          pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
module instr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       push_in,
    input  logic [WIDTH-1:0]           push_data_in,
    input  logic                       pop_in,
    output logic [WIDTH-1:0]           head_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       empty_out,
    output logic                       full_out
);
    import gpu_pkg::*;

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign empty_out = (count == '0);
    assign full_out  = (count == CNTW'(DEPTH));
    assign count_out = count;
    assign head_out  = mem[rd_ptr];
    assign do_push   = push_in && (!full_out || pop_in);
    assign do_pop    = pop_in && !empty_out;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push && !flush_in) mem[wr_ptr] <= push_data_in;
    end

    // The fetch credit scheme must make a push into a full, non-draining FIFO impossible.
    assert property (@(posedge clk_in) disable iff (rst_in)
        !(push_in && full_out && !pop_in && !flush_in));

endmodule

// File: rtl/instr_fetch.sv
// Credit-limited instruction fetch: issues BRAM reads, tracks them in flight and buffers results.
//  state   | meaning
//  S_IDLE  | waiting for start_in; done_out held after a completed program
//  S_FETCH | issuing reads while buffer + in-flight credit allows
//  S_END   | all addresses issued; draining in-flight reads and buffer
module instr_fetch #(
    parameter int INSTRUCTION_WIDTH = gpu_pkg::INSTRUCTION_WIDTH,
    parameter int INSTRUCTION_COUNT = 8,
    parameter int BRAM_LATENCY      = 2,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   start_in,
    input  logic                                   redirect_in,
    input  logic [$clog2(INSTRUCTION_COUNT+1)-1:0] redirect_pc_in,
    output logic [$clog2(INSTRUCTION_COUNT)-1:0]   bram_addr_out,
    output logic                                   bram_en_out,
    input  logic [INSTRUCTION_WIDTH-1:0]           bram_data_in,
    output logic [INSTRUCTION_WIDTH-1:0]           instr_out,
    output logic [$clog2(INSTRUCTION_COUNT+1)-1:0] pc_out,
    output logic                                   instr_valid_out,
    input  logic                                   instr_ready_in,
    output logic                                   done_out
);
    import gpu_pkg::*;

    localparam int PW  = $clog2(INSTRUCTION_COUNT + 1);
    localparam int AW  = $clog2(INSTRUCTION_COUNT);
    localparam int CW  = $clog2(FIFO_DEPTH + BRAM_LATENCY + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int EW  = INSTRUCTION_WIDTH + PW;
    localparam logic [PW-1:0] PC_LAST = PW'(INSTRUCTION_COUNT);

    fetch_state_t          state;
    logic [PW-1:0]         fetch_pc;
    logic [BRAM_LATENCY-1:0] infl_valid;
    logic [PW-1:0]         infl_pc [BRAM_LATENCY];
    logic [CW-1:0]         infl_count;
    logic [CW-1:0]         credit_used;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [EW-1:0]         head_entry;
    logic                  issue;
    logic                  arrive;
    logic                  pop;

    always_comb begin
        infl_count = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            infl_count = infl_count + CW'(infl_valid[i]);
        end
        credit_used = infl_count + CW'(fifo_count);
    end

    // Reads in flight already own a FIFO slot, so the buffer can never overflow.
    assign issue = (state == S_FETCH) && (fetch_pc < PC_LAST) && !fifo_full
                   && (credit_used < CW'(FIFO_DEPTH)) && !redirect_in;

    assign bram_en_out     = issue;
    assign bram_addr_out   = fetch_pc[AW-1:0];
    assign arrive          = infl_valid[BRAM_LATENCY-1] && !redirect_in;
    assign instr_valid_out = !fifo_empty;
    assign pop             = instr_valid_out && instr_ready_in;
    assign instr_out       = instr_valid_out ? head_entry[EW-1:PW] : '0;
    assign pc_out          = instr_valid_out ? head_entry[PW-1:0] : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            infl_valid <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) infl_pc[i] <= '0;
        end else begin
            for (int i = BRAM_LATENCY - 1; i > 0; i--) begin
                infl_valid[i] <= infl_valid[i-1] && !redirect_in;
                infl_pc[i]    <= infl_pc[i-1];
            end
            infl_valid[0] <= issue;
            infl_pc[0]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            fetch_pc <= '0;
            done_out <= 1'b0;
        end else if (redirect_in) begin
            fetch_pc <= redirect_pc_in;
            state    <= (redirect_pc_in >= PC_LAST) ? S_END : S_FETCH;
            done_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        state    <= S_FETCH;
                        fetch_pc <= '0;
                        done_out <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (issue) fetch_pc <= fetch_pc + PW'(1);
                    if (fetch_pc >= PC_LAST) state <= S_END;
                end
                S_END: begin
                    if (fifo_empty && (infl_valid == '0)) begin
                        state    <= S_IDLE;
                        done_out <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    instr_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_in    (redirect_in),
        .push_in     (arrive),
        .push_data_in({bram_data_in, infl_pc[BRAM_LATENCY-1]}),
        .pop_in      (pop),
        .head_out    (head_entry),
        .count_out   (fifo_count),
        .empty_out   (fifo_empty),
        .full_out    (fifo_full)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected pc stream per program run, checked on every transfer.
module tb_instr_fetch;
    localparam int IW  = 32;
    localparam int IC  = 8;
    localparam int LAT = 2;
    localparam int DEP = 4;
    localparam int PW  = $clog2(IC + 1);
    localparam int AW  = $clog2(IC);

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic          redirect_in;
    logic [PW-1:0] redirect_pc_in;
    logic [AW-1:0] bram_addr_out;
    logic          bram_en_out;
    logic [IW-1:0] bram_data_in;
    logic [IW-1:0] instr_out;
    logic [PW-1:0] pc_out;
    logic          instr_valid_out;
    logic          instr_ready_in;
    logic          done_out;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    instr_fetch #(
        .INSTRUCTION_WIDTH(IW),
        .INSTRUCTION_COUNT(IC),
        .BRAM_LATENCY(LAT),
        .FIFO_DEPTH(DEP)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .bram_addr_out  (bram_addr_out),
        .bram_en_out    (bram_en_out),
        .bram_data_in   (bram_data_in),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid_out(instr_valid_out),
        .instr_ready_in (instr_ready_in),
        .done_out       (done_out)
    );

    // Program memory: word = 0xA000_0000 + addr, two-cycle read latency
    logic [IW-1:0] bram_d1, bram_d2;
    always @(posedge clk) begin
        bram_d1 <= bram_en_out ? (32'hA000_0000 + IW'(bram_addr_out)) : '0;
        bram_d2 <= bram_d1;
    end
    assign bram_data_in = bram_d2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted head transfer must be the next expected program word
    always @(negedge clk) begin : monitor
        int e;
        if (!rst_in && instr_valid_out && instr_ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_transfer actual pc=%0d required none", pc_out);
            end else begin
                e = exp_q.pop_front();
                check("xfer_pc", 64'(pc_out), 64'(e));
                check("xfer_instr", 64'(instr_out), 64'(32'hA000_0000 + e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int from);
        exp_q.delete();
        for (int p = from; p < IC; p++) exp_q.push_back(p);
    endtask

    task automatic do_start();
        start_in = 1'b1;
        fill(0);
        cyc();
        start_in = 1'b0;
    endtask

    task automatic do_redirect(input int target);
        redirect_in    = 1'b1;
        redirect_pc_in = PW'(target);
        cyc();
        redirect_in = 1'b0;
        fill(target);
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        while (!done_out && n < bound) begin
            cyc();
            n++;
        end
        check(name, 64'(done_out), 64'd1);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_en"}, 64'(bram_en_out), 64'd0);
        check({name, "_addr"}, 64'(bram_addr_out), 64'd0);
        check({name, "_valid"}, 64'(instr_valid_out), 64'd0);
        check({name, "_instr"}, 64'(instr_out), 64'd0);
        check({name, "_pc"}, 64'(pc_out), 64'd0);
        check({name, "_done"}, 64'(done_out), 64'd0);
    endtask

    initial begin : stim
        int issues;
        int seen_valid;
        logic [PW-1:0] pc_a;
        logic [IW-1:0] ins_a;
        logic found;
        int n;
        int nred;
        int r;

        rst_in         = 1'b1;
        start_in       = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = '0;
        instr_ready_in = 1'b0;
        #2;
        check_reset_outputs("reset");
        cyc();
        rst_in = 1'b0;
        cyc();
        check("idle_no_issue", 64'(bram_en_out), 64'd0);

        // Straight-line program with ready always high
        instr_ready_in = 1'b1;
        do_start();
        check("start_done_low", 64'(done_out), 64'd0);
        wait_done(60, "t1_done");
        repeat (3) cyc();
        check("t1_done_held", 64'(done_out), 64'd1);
        check("t1_idle_no_issue", 64'(bram_en_out), 64'd0);

        // Back-pressure: ready low for 20 cycles after start
        instr_ready_in = 1'b0;
        do_start();
        check("t2_done_clear", 64'(done_out), 64'd0);
        issues = 0;
        pc_a   = '0;
        ins_a  = '0;
        for (int c = 0; c < 20; c++) begin
            if (bram_en_out) issues++;
            if (c == 6) begin
                pc_a  = pc_out;
                ins_a = instr_out;
            end
            cyc();
        end
        check("t2_issues", 64'(issues), 64'(DEP));
        check("t2_en_stalled", 64'(bram_en_out), 64'd0);
        check("t2_valid", 64'(instr_valid_out), 64'd1);
        check("t2_pc_stable", 64'(pc_out), 64'(pc_a));
        check("t2_instr_stable", 64'(instr_out), 64'(ins_a));
        check("t2_head_pc", 64'(pc_out), 64'd0);
        instr_ready_in = 1'b1;
        wait_done(80, "t2_done");

        // Redirect to 5 while pc 2 is being accepted
        do_start();
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (instr_valid_out && pc_out == PW'(2)) found = 1'b1;
            else cyc();
        end
        check("t3_pc2_seen", 64'(found), 64'd1);
        do_redirect(5);
        wait_done(60, "t3_done");

        // Redirect to end of program: nothing further issued
        do_start();
        repeat (3) cyc();
        do_redirect(IC);
        check("t4_valid_flushed", 64'(instr_valid_out), 64'd0);
        check("t4_no_issue", 64'(bram_en_out), 64'd0);
        wait_done(LAT, "t4_done");

        // Reset mid-fetch with reads in flight
        do_start();
        repeat (3) cyc();
        rst_in = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("t5_reset");
        cyc();
        cyc();
        rst_in = 1'b0;
        issues     = 0;
        seen_valid = 0;
        for (int c = 0; c < 10; c++) begin
            if (bram_en_out) issues++;
            if (instr_valid_out) seen_valid++;
            cyc();
        end
        check("t5_no_issue", 64'(issues), 64'd0);
        check("t5_no_valid", 64'(seen_valid), 64'd0);
        check("t5_done_low", 64'(done_out), 64'd0);
        do_start();
        wait_done(60, "t5_done");

        // Randomised runs: random ready, occasional redirects and ignored starts
        for (int it = 0; it < 8; it++) begin
            instr_ready_in = 1'b1;
            if (it[0]) begin
                start_in = 1'b1;
                do_redirect($urandom_range(0, IC));
                start_in = 1'b0;
            end else begin
                do_start();
            end
            n    = 0;
            nred = 0;
            while (!done_out && n < 400) begin
                instr_ready_in = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 29);
                if (r == 0 && nred < 3) begin
                    nred++;
                    do_redirect($urandom_range(0, IC));
                end else if (r == 1) begin
                    start_in = 1'b1;
                    cyc();
                    start_in = 1'b0;
                end else begin
                    cyc();
                end
                n++;
            end
            check("rand_done", 64'(done_out), 64'd1);
            check("rand_drained", 64'(exp_q.size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
